// File: rtl/elixirchip_es1_spu_any_sched.sv
// elixirchip_es1_spu_any_sched
// Round-robin scheduler feeding a fixed-latency OR-reduction unit. Each
// requester may have one operation outstanding; the result comes back on
// that requester's own m_valid/m_data lane LATENCY enabled edges after the
// accept edge (the accept edge itself counts as the first).
module elixirchip_es1_spu_any_sched #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_BITS  = 36,
   parameter int LATENCY    = 2,
   parameter     DEVICE     = "RTL",
   parameter     SIMULATION = "false",
   parameter     DEBUG      = "false"
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           cke,
   input  logic                           s_flush,
   input  logic [NUM_REQ*DATA_BITS-1:0]   s_data,
   input  logic [NUM_REQ-1:0]             s_valid,
   output logic [NUM_REQ-1:0]             s_ready,
   output logic [NUM_REQ-1:0]             m_data,
   output logic [NUM_REQ-1:0]             m_valid,
   output logic                           busy,
   output logic [15:0]                    issue_count
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW    = PTR_W + 1;

   logic [PTR_W-1:0]   ptr;
   logic [PTR_W-1:0]   ptr_next;
   logic [NUM_REQ-1:0] pending;
   logic [NUM_REQ-1:0] elig;
   logic [NUM_REQ-1:0] grant;
   logic [PTR_W-1:0]   grant_idx;
   logic [CW-1:0]      cand;
   logic               found;
   logic               accept;
   logic               acc_res;

   logic               last_valid;
   logic [PTR_W-1:0]   last_idx;
   logic               last_res;
   logic [NUM_REQ-1:0] last_onehot;

   // Round-robin search from ptr over requesters that have no op outstanding.
   always_comb begin
      elig      = s_valid & ~pending;
      found     = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = {1'b0, ptr} + CW'(i);
         if (cand >= CW'(NUM_REQ)) begin
            cand = cand - CW'(NUM_REQ);
         end else begin
            cand = cand;
         end
         if (!found && elig[cand[PTR_W-1:0]]) begin
            found     = 1'b1;
            grant_idx = cand[PTR_W-1:0];
         end else begin
            found     = found;
         end
      end
   end

   // Grant is suppressed while stalled, flushing or held in reset.
   always_comb begin
      if (found) begin
         grant = NUM_REQ'(1) << grant_idx;
      end else begin
         grant = '0;
      end
      if (reset && cke && !s_flush) begin
         s_ready = grant;
      end else begin
         s_ready = '0;
      end
      accept = |s_ready;
   end

   // OR-reduce the operand of the granted requester.
   always_comb begin
      acc_res = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         acc_res = acc_res | (grant[k] & (|s_data[k*DATA_BITS +: DATA_BITS]));
      end
   end

   // Pointer moves to the slot just after the winner, with wrap.
   always_comb begin
      if (grant_idx == PTR_W'(NUM_REQ - 1)) begin
         ptr_next = '0;
      end else begin
         ptr_next = grant_idx + PTR_W'(1);
      end
   end

   generate
      if (LATENCY > 1) begin : g_pipe
         logic [LATENCY-2:0]            st_valid;
         logic [LATENCY-2:0][PTR_W-1:0] st_idx;
         logic [LATENCY-2:0]            st_res;

         // Intermediate stages between the accept edge and the output register.
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               st_valid <= '0;
               st_idx   <= '0;
               st_res   <= '0;
            end else if (cke) begin
               if (s_flush) begin
                  st_valid <= '0;
               end else begin
                  st_valid[0] <= accept;
                  st_idx[0]   <= grant_idx;
                  st_res[0]   <= acc_res;
                  for (int i = 1; i < LATENCY - 1; i++) begin
                     st_valid[i] <= st_valid[i-1];
                     st_idx[i]   <= st_idx[i-1];
                     st_res[i]   <= st_res[i-1];
                  end
               end
            end
         end

         assign last_valid = st_valid[LATENCY-2];
         assign last_idx   = st_idx[LATENCY-2];
         assign last_res   = st_res[LATENCY-2];
      end else begin : g_direct
         assign last_valid = accept;
         assign last_idx   = grant_idx;
         assign last_res   = acc_res;
      end
   endgenerate

   // Decode the stage feeding the output register into a per-requester lane.
   always_comb begin
      if (last_valid) begin
         last_onehot = NUM_REQ'(1) << last_idx;
      end else begin
         last_onehot = '0;
      end
   end

   // Arbiter state, pending flags, outputs and accept counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr         <= '0;
         pending     <= '0;
         m_valid     <= '0;
         m_data      <= '0;
         issue_count <= 16'd0;
      end else if (cke) begin
         if (s_flush) begin
            pending <= '0;
            m_valid <= '0;
         end else begin
            pending <= (pending | s_ready) & ~last_onehot;
            m_valid <= last_onehot;
            m_data  <= (m_data & ~last_onehot) | (last_res ? last_onehot : '0);
            if (accept) begin
               ptr         <= ptr_next;
               issue_count <= issue_count + 16'd1;
            end
         end
      end
   end

   assign busy = |pending;

endmodule

// File: doc/elixirchip_es1_spu_any_sched.md
ELIXIRCHIP_ES1_SPU_ANY_SCHED -- requirements
Module: elixirchip_es1_spu_any_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..16).
REQ-002 SHALL have parameter DATA_BITS, default 36, operand width per requester.
REQ-003 SHALL have parameter LATENCY, default 2, accept-to-result cycles (>=1).
REQ-004 SHALL have parameters DEVICE "RTL", SIMULATION "false", DEBUG "false", passed through to internal logic.
REQ-005 SHALL have port clk  in  1  clock, all state on rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port cke  in  1  clock enable; low freezes all state.
REQ-008 SHALL have port s_flush  in  1  synchronous abort of all in-flight operations.
REQ-009 SHALL have port s_data  in  NUM_REQ x DATA_BITS  operand per requester.
REQ-010 SHALL have port s_valid  in  NUM_REQ  request per requester.
REQ-011 SHALL have port s_ready  out  NUM_REQ  one-hot grant; accept = s_valid[k] & s_ready[k].
REQ-012 SHALL have port m_data  out  NUM_REQ  OR-reduction result per requester.
REQ-013 SHALL have port m_valid  out  NUM_REQ  one-cycle result strobe per requester.
REQ-014 SHALL have port busy  out  1  any operation outstanding.
REQ-015 SHALL have port issue_count  out  16  accepted-operation counter.

Function
REQ-016 SHALL keep pending[k], set on accept of requester k, cleared on the edge that asserts m_valid[k]; at most one outstanding op per requester.
REQ-017 SHALL treat requester k as eligible when s_valid[k] & ~pending[k]; s_ready SHALL be combinational, at most one bit high, only for an eligible requester.
REQ-018 SHALL arbitrate round-robin: search starts at pointer ptr, ascending with wrap; after accepting k, ptr <= (k+1) mod NUM_REQ; ptr unchanged when nothing accepted.
REQ-019 SHALL drive s_ready all-zero while cke=0 or s_flush=1.
REQ-020 SHALL compute result = OR of all DATA_BITS of the accepted s_data, carried with requester index and valid through exactly LATENCY cke-enabled registered stages.
REQ-021 SHALL assert m_valid[k] for one cke cycle exactly LATENCY cke-enabled edges after the accept edge, with m_data[k] = result; m_data[k] SHALL hold its last value otherwise.
REQ-022 SHALL allow requester k to be granted in the same cycle m_valid[k] is high (back-to-back throughput of one op per requester per LATENCY cycles).
REQ-023 SHALL accept up to one op per cycle overall; with NUM_REQ >= LATENCY continuously requesting, an accept SHALL occur every cycle.
REQ-024 SHALL, when cke=0, hold every register including m_valid, m_data, ptr, pending, issue_count.
REQ-025 SHALL, on cke=1 & s_flush=1, clear all pipeline valids and pending, drive m_valid to 0 next cycle, leave m_data, ptr, issue_count unchanged.
REQ-026 SHALL increment issue_count by 1 per accept, wrapping 0xFFFF -> 0x0000.
REQ-027 SHALL drive busy = |pending (combinational from registers).

Reset
REQ-028 SHALL, while reset=0, asynchronously force ptr=0, pending=0, pipeline valids=0, m_valid=0, m_data=0, issue_count=0, busy=0, s_ready=0.
REQ-029 SHALL resume arbitration on the first clk edge after reset deasserts; reset mid-operation SHALL discard in-flight results without any m_valid.

Verification
REQ-030 SHALL cover single request: NUM_REQ=4, LATENCY=2, s_valid=0001, s_data[0]=0x000000400 -> s_ready=0001 same cycle, m_valid=0001 and m_data[0]=1 two cycles later, issue_count=1.
REQ-031 SHALL cover fairness: all four s_valid held high, all zero data -> grants 0,1,2,3,0,... one per cycle, each m_valid exactly 2 cycles after its grant with m_data=0.
REQ-032 SHALL cover pending block: requester 2 granted, s_valid[2] held -> s_ready[2]=0 next cycle, re-granted in the cycle m_valid[2]=1.
REQ-033 SHALL cover cke stall: cke=0 for 3 cycles mid-pipeline -> no state change, s_ready=0, m_valid appears after 2 enabled edges total.
REQ-034 SHALL cover flush and reset: s_flush with 2 ops in flight -> no m_valid follows, busy=0; reset=0 mid-op -> all outputs 0 immediately, no stale m_valid after release.
REQ-035 SHALL cover counter wrap: preload-by-stimulus 65536 accepts -> issue_count returns to 0x0000.
